adbg_jsp_apb_fifo_biu: RTL and testbench
========================================

Name: adbg_jsp_apb_fifo_biu

Overview:
- Next-generation JTAG Serial Port bus interface unit.
- Links the debug-side JSP core byte strobes to an 8-bit APB slave.
- Uses two parametrised-depth FIFOs:
  - RX: debugger to CPU.
  - TX: CPU to debugger.
- Adds a 16550-style register map, programmable RX trigger level, overrun detection and a registered prioritised interrupt.
- Single clock domain; the debug-side strobes are already synchronised to clk_i by the JSP core.

Parameters:
- DEPTH, 16: entries per FIFO. Power of two, DEPTH >= 4.
- CNT_W, $clog2(DEPTH+1): width of the level/count outputs. Derived; do not override.

Ports:
- clk_i  in  1  block clock; APB and debug side.
- rst_i  in  1  synchronous, active-high reset.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  APB write.
- PADDR  in  3  register address.
- PWDATA  in  8  APB write data.
- PRDATA  out  8  APB read data; combinational in the access phase.
- PREADY  out  1  tied 1; zero wait states.
- PSLVERR  out  1  error response.
- dbg_data_i  in  8  byte from the debugger.
- dbg_wr_strobe_i  in  1  push dbg_data_i into RX.
- dbg_rd_strobe_i  in  1  pop TX head.
- dbg_data_o  out  8  TX head byte; 0 when TX is empty.
- dbg_bytes_available_o  out  CNT_W  TX occupancy.
- dbg_bytes_free_o  out  CNT_W  RX free space.
- int_o  out  1  CPU interrupt, registered.

Behaviour:
- Reset: all of the following are cleared.
  - Both FIFOs empty; IER=0; trigger code=0; SCR=0; overrun=0; thre_pending=0; int_o=0.
  - dbg_bytes_available_o=0; dbg_bytes_free_o=DEPTH.
- APB access: an access = PSEL & PENABLE. All side effects take place on that cycle's clk_i edge.
- Register map:
  - 0: R pops RX and returns its head. W pushes TX.
  - 1: IER. bit0 = RX-level interrupt enable; bit1 = TX-empty interrupt enable. Other bits read 0.
  - 2: R = IIR. {2'b11, 2'b00, id[3:0]} with id 0x4 = RX, 0x2 = THRE, 0x1 = none.
  - 2: W = FCR.
    - bit1 clears RX; bit2 clears TX.
    - bits[7:6] set the trigger: 0 → 1, 1 → DEPTH/4, 2 → DEPTH/2, 3 → DEPTH-1.
  - 5: LSR, read-only.
    - bit0 = RX non-empty; bit1 = overrun; bit5 = TX empty; bit6 = TX empty.
    - Reading LSR clears overrun.
  - 7: SCR, read/write scratch.
  - 3, 4, 6: read 0, writes ignored. See Optional Feature for 3 and 4.
- Errors:
  - PSLVERR=1 during the access phase of a read of 0 while RX is empty. PRDATA=0, no pop.
  - PSLVERR=1 during the access phase of a write of 0 while TX is full. Byte dropped.
  - PSLVERR=0 otherwise.
- Debug side:
  - dbg_wr_strobe_i with RX full: byte dropped, overrun set.
  - dbg_rd_strobe_i with TX empty: ignored.
- Simultaneous push and pop on the same FIFO in one cycle: both happen and the count is unchanged.
  - When full, this is allowed; no overrun and no PSLVERR.
  - When empty, the pop is ignored and the push is taken.
- FCR clear in the same cycle as a push to that FIFO: clear wins, push dropped, no overrun.
- Pointers are log2(DEPTH) bits wide and wrap naturally. Count is CNT_W bits, range 0..DEPTH.
- thre_pending:
  - Set when TX transitions to empty by a pop or clear.
  - Set when IER bit1 is written 0→1 while TX is empty.
  - Cleared by an IIR read that returns 0x2, or by any TX write.
- Interrupt causes:
  - RX cause = IER[0] & (rx_count >= trigger).
  - THRE cause = IER[1] & tx_empty & thre_pending.
  - Priority RX > THRE.
- IIR/int_o timing:
  - IIR reflects the causes combinationally.
  - int_o = registered OR of the causes, one cycle latency.

Optional Feature:
- Macro: ADBG_JSP_LEVEL_REGS_EN.
- Defined: register 3 reads the RX count; register 4 reads the TX free space. Both are zero-extended, saturating at 255.
- Undefined: registers 3 and 4 read 0. No extra logic.

Test Plan:
1. Reset, DEPTH=16 → dbg_bytes_free_o=16, dbg_bytes_available_o=0, LSR=0x60, IIR=0xC1, int_o=0.
2. Debugger pushes 0xA5, 0x3C; IER=0x01; trigger 1 → int_o=1 one cycle after the first push, IIR=0xC4. APB reads of 0 return 0xA5 then 0x3C. int_o falls one cycle after the last pop.
3. Debugger pushes 17 bytes → 17th dropped, LSR=0x63. LSR read clears overrun; next LSR=0x61.
4. CPU writes 16 bytes → a 17th write gives PSLVERR=1. Then an APB write plus dbg_rd_strobe_i in the same cycle → count stays 16 and the FIFO order is preserved.
5. IER=0x02 with TX empty → IIR=0xC2, int_o=1. IIR read clears it. Debugger drains a 1-byte TX → thre_pending set again.
6. FCR=0x82 (clear RX, trigger 8) while the debugger pushes in the same cycle → RX empty. With RX at 7 bytes the RX interrupt stays low; at 8 bytes it fires. With ADBG_JSP_LEVEL_REGS_EN, register 3 reads 8.

Source files
------------

// File: rtl/adbg_jsp_apb_fifo_biu.sv
// adbg_jsp_apb_fifo_biu
//   JTAG Serial Port bus interface unit. It bridges the debug-side JSP core
//   byte strobes to an 8-bit APB slave through two FIFOs:
//     RX (debugger -> CPU) and TX (CPU -> debugger).
//   The APB side sees a 16550-style register map:
//     0 RBR/THR, 1 IER, 2 IIR/FCR, 5 LSR, 7 SCR.
//   It also provides a programmable RX trigger, overrun detection and a
//   registered, prioritised interrupt.
//   Optional macro ADBG_JSP_LEVEL_REGS_EN: when defined, register 3 returns
//   the RX count and register 4 returns the TX free space, each saturating
//   at 255. When undefined, both registers read 0.
// Ports:
//   clk_i, rst_i (sync, active-high)
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA -> PRDATA/PREADY/PSLVERR  APB slave
//   dbg_data_i, dbg_wr_strobe_i  push a byte into RX
//   dbg_rd_strobe_i, dbg_data_o  pop the TX head / TX head byte (0 if empty)
//   dbg_bytes_available_o        TX occupancy
//   dbg_bytes_free_o             RX free space
//   int_o                        registered CPU interrupt
module adbg_jsp_apb_fifo_biu #(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             PSEL,
  input  logic             PENABLE,
  input  logic             PWRITE,
  input  logic [2:0]       PADDR,
  input  logic [7:0]       PWDATA,
  output logic [7:0]       PRDATA,
  output logic             PREADY,
  output logic             PSLVERR,
  input  logic [7:0]       dbg_data_i,
  input  logic             dbg_wr_strobe_i,
  input  logic             dbg_rd_strobe_i,
  output logic [7:0]       dbg_data_o,
  output logic [CNT_W-1:0] dbg_bytes_available_o,
  output logic [CNT_W-1:0] dbg_bytes_free_o,
  output logic             int_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [7:0]       r_rx_mem [DEPTH];
  logic [7:0]       r_tx_mem [DEPTH];
  logic [AW-1:0]    r_rx_wptr, r_rx_rptr, r_tx_wptr, r_tx_rptr;
  logic [CNT_W-1:0] r_rx_cnt, r_tx_cnt;
  logic [1:0]       r_ier, r_trig_code;
  logic [7:0]       r_scr;
  logic             r_ovr, r_thre_pend, r_int;

  logic w_access, w_rd, w_wr, w_tx_wr0;
  logic w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
  logic w_rx_clr, w_tx_clr, w_rx_pop, w_rx_push, w_rx_ovr, w_tx_pop, w_tx_push;
  logic w_rx_cause, w_thre_cause, w_thre_set, w_thre_clr;
  logic [CNT_W-1:0] w_trig;
  logic [3:0] w_iir_id;
  logic [7:0] w_lsr, w_rdata;

  assign w_access   = PSEL & PENABLE;
  assign w_rd       = w_access & ~PWRITE;
  assign w_wr       = w_access & PWRITE;
  assign w_tx_wr0   = w_wr & (PADDR == 3'd0);
  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == FULL_CNT);
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_tx_full  = (r_tx_cnt == FULL_CNT);

  assign w_rx_clr  = w_wr & (PADDR == 3'd2) & PWDATA[1];
  assign w_tx_clr  = w_wr & (PADDR == 3'd2) & PWDATA[2];
  assign w_rx_pop  = w_rd & (PADDR == 3'd0) & ~w_rx_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // accepted then. A clear drops the push silently, without flagging overrun.
  assign w_rx_push = dbg_wr_strobe_i & ~w_rx_clr & (~w_rx_full | w_rx_pop);
  assign w_rx_ovr  = dbg_wr_strobe_i & ~w_rx_clr & w_rx_full & ~w_rx_pop;
  assign w_tx_pop  = dbg_rd_strobe_i & ~w_tx_empty & ~w_tx_clr;
  assign w_tx_push = w_tx_wr0 & (~w_tx_full | w_tx_pop);

  assign PREADY  = 1'b1;
  assign PSLVERR = (w_rd & (PADDR == 3'd0) & w_rx_empty) |
                   (w_tx_wr0 & w_tx_full & ~w_tx_pop);

  always_comb begin
    w_trig = CNT_W'(1);
    case (r_trig_code)
      2'd1:    w_trig = CNT_W'(DEPTH / 4);
      2'd2:    w_trig = CNT_W'(DEPTH / 2);
      2'd3:    w_trig = CNT_W'(DEPTH - 1);
      default: w_trig = CNT_W'(1);
    endcase
  end

  assign w_rx_cause   = r_ier[0] & (r_rx_cnt >= w_trig);
  assign w_thre_cause = r_ier[1] & w_tx_empty & r_thre_pend;
  assign w_iir_id     = w_rx_cause ? 4'h4 : (w_thre_cause ? 4'h2 : 4'h1);
  assign w_lsr        = {1'b0, w_tx_empty, w_tx_empty, 3'b000, r_ovr, ~w_rx_empty};

  // thre_pending is set only when TX actually goes from non-empty to empty,
  // or when THRE is enabled while TX is already empty.
  assign w_thre_set = (~w_tx_empty & ((w_tx_pop & (r_tx_cnt == CNT_W'(1)) & ~w_tx_push) | w_tx_clr)) |
                      (w_wr & (PADDR == 3'd1) & PWDATA[1] & ~r_ier[1] & w_tx_empty);
  assign w_thre_clr = (w_rd & (PADDR == 3'd2) & (w_iir_id == 4'h2)) | w_tx_wr0;

`ifdef ADBG_JSP_LEVEL_REGS_EN
  logic [31:0] w_rx_lvl32, w_tx_free32;
  logic [7:0]  w_rx_lvl8, w_tx_free8;
  assign w_rx_lvl32  = 32'(r_rx_cnt);
  assign w_tx_free32 = 32'(FULL_CNT - r_tx_cnt);
  assign w_rx_lvl8   = (w_rx_lvl32 > 32'd255) ? 8'hFF : w_rx_lvl32[7:0];
  assign w_tx_free8  = (w_tx_free32 > 32'd255) ? 8'hFF : w_tx_free32[7:0];
`endif

  always_comb begin
    w_rdata = '0;
    case (PADDR)
      3'd0: w_rdata = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rptr];
      3'd1: w_rdata = {6'b0, r_ier};
      3'd2: w_rdata = {4'b1100, w_iir_id};
`ifdef ADBG_JSP_LEVEL_REGS_EN
      3'd3: w_rdata = w_rx_lvl8;
      3'd4: w_rdata = w_tx_free8;
`endif
      3'd5: w_rdata = w_lsr;
      3'd7: w_rdata = r_scr;
      default: w_rdata = '0;
    endcase
  end

  assign PRDATA                = w_rd ? w_rdata : '0;
  assign dbg_data_o            = w_tx_empty ? 8'h00 : r_tx_mem[r_tx_rptr];
  assign dbg_bytes_available_o = r_tx_cnt;
  assign dbg_bytes_free_o      = FULL_CNT - r_rx_cnt;
  assign int_o                 = r_int;

  always_ff @(posedge clk_i) begin
    if (w_rx_push) r_rx_mem[r_rx_wptr] <= dbg_data_i;
    if (w_tx_push) r_tx_mem[r_tx_wptr] <= PWDATA;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || w_rx_clr) begin
      r_rx_wptr <= '0;
      r_rx_rptr <= '0;
      r_rx_cnt  <= '0;
    end else begin
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
      if (w_rx_push && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + 1'b1;
      else if (!w_rx_push && w_rx_pop) r_rx_cnt <= r_rx_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || w_tx_clr) begin
      r_tx_wptr <= '0;
      r_tx_rptr <= '0;
      r_tx_cnt  <= '0;
    end else begin
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + 1'b1;
      if (w_tx_push && !w_tx_pop)      r_tx_cnt <= r_tx_cnt + 1'b1;
      else if (!w_tx_push && w_tx_pop) r_tx_cnt <= r_tx_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ier       <= '0;
      r_trig_code <= '0;
      r_scr       <= '0;
      r_ovr       <= 1'b0;
      r_thre_pend <= 1'b0;
      r_int       <= 1'b0;
    end else begin
      if (w_wr && PADDR == 3'd1) r_ier       <= PWDATA[1:0];
      if (w_wr && PADDR == 3'd2) r_trig_code <= PWDATA[7:6];
      if (w_wr && PADDR == 3'd7) r_scr       <= PWDATA;
      // A fresh overrun wins over an LSR read in the same cycle so it is not lost.
      if (w_rx_ovr)                       r_ovr <= 1'b1;
      else if (w_rd && PADDR == 3'd5)     r_ovr <= 1'b0;
      if (w_thre_set)      r_thre_pend <= 1'b1;
      else if (w_thre_clr) r_thre_pend <= 1'b0;
      r_int <= w_rx_cause | w_thre_cause;
    end
  end
endmodule

// File: tb/tb_adbg_jsp_apb_fifo_biu.sv
module tb_adbg_jsp_apb_fifo_biu;
  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             PSEL, PENABLE, PWRITE;
  logic [2:0]       PADDR;
  logic [7:0]       PWDATA, PRDATA;
  logic             PREADY, PSLVERR;
  logic [7:0]       dbg_data_i, dbg_data_o;
  logic             dbg_wr_strobe_i, dbg_rd_strobe_i;
  logic [CNT_W-1:0] dbg_bytes_available_o, dbg_bytes_free_o;
  logic             int_o;

  always #5 clk_i = ~clk_i;

  adbg_jsp_apb_fifo_biu #(.DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .dbg_data_i(dbg_data_i), .dbg_wr_strobe_i(dbg_wr_strobe_i),
    .dbg_rd_strobe_i(dbg_rd_strobe_i), .dbg_data_o(dbg_data_o),
    .dbg_bytes_available_o(dbg_bytes_available_o),
    .dbg_bytes_free_o(dbg_bytes_free_o), .int_o(int_o)
  );

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: byte queues plus register shadows.
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  logic [1:0] m_ier, m_trig;
  logic [7:0] m_scr;
  bit         m_ovr, m_thre, m_int;

  function automatic int trig_lvl();
    case (m_trig)
      2'd0: return 1;
      2'd1: return DEPTH / 4;
      2'd2: return DEPTH / 2;
      default: return DEPTH - 1;
    endcase
  endfunction

  function automatic bit rx_cause();
    return m_ier[0] && (rxq.size() >= trig_lvl());
  endfunction

  function automatic bit thre_cause();
    return m_ier[1] && (txq.size() == 0) && m_thre;
  endfunction

  function automatic logic [3:0] iir_id();
    if (rx_cause()) return 4'h4;
    if (thre_cause()) return 4'h2;
    return 4'h1;
  endfunction

  function automatic logic [7:0] reg_val(input logic [2:0] a);
    int v;
    case (a)
      3'd0: return (rxq.size() == 0) ? 8'h00 : rxq[0];
      3'd1: return {6'b0, m_ier};
      3'd2: return {4'hC, iir_id()};
`ifdef ADBG_JSP_LEVEL_REGS_EN
      3'd3: begin v = rxq.size(); return (v > 255) ? 8'hFF : 8'(v); end
      3'd4: begin v = DEPTH - txq.size(); return (v > 255) ? 8'hFF : 8'(v); end
`endif
      3'd5: return {1'b0, txq.size() == 0, txq.size() == 0, 3'b000, m_ovr, rxq.size() != 0};
      3'd7: return m_scr;
      default: return 8'h00;
    endcase
  endfunction

  // One clock cycle: drive, check outputs mid-cycle, advance the model, clock.
  // cexp >= 0 adds a fixed-value check of PRDATA.
  task automatic step(input logic sel, input logic en, input logic wr,
                      input logic [2:0] a, input logic [7:0] wd,
                      input logic dwr, input logic [7:0] dd, input logic drd,
                      input int cexp = -1);
    bit acc, exp_err, nxt_int, popped, rclr, tclr;
    int tx_pre;
    logic [3:0] id_pre;
    PSEL = sel; PENABLE = en; PWRITE = wr; PADDR = a; PWDATA = wd;
    dbg_wr_strobe_i = dwr; dbg_data_i = dd; dbg_rd_strobe_i = drd;
    #2;
    acc = sel && en;
    exp_err = acc && ((!wr && a == 0 && rxq.size() == 0) ||
                      (wr && a == 0 && txq.size() == DEPTH && !drd));
    chk("pslverr", PSLVERR, exp_err);
    chk("pready", PREADY, 1);
    if (acc && !wr) chk("prdata", PRDATA, reg_val(a));
    if (cexp >= 0) chk("prdata_const", PRDATA, cexp);
    chk("dbg_data", dbg_data_o, (txq.size() != 0) ? txq[0] : 8'h00);
    chk("avail", dbg_bytes_available_o, txq.size());
    chk("free", dbg_bytes_free_o, DEPTH - rxq.size());
    chk("int_o", int_o, m_int);

    nxt_int = rx_cause() || thre_cause();
    id_pre  = iir_id();
    tx_pre  = txq.size();
    rclr = acc && wr && a == 2 && wd[1];
    tclr = acc && wr && a == 2 && wd[2];
    popped = 0;
    if (acc && !wr) begin
      if (a == 0 && rxq.size() != 0) void'(rxq.pop_front());
      if (a == 2 && id_pre == 4'h2) m_thre = 0;
      if (a == 5) m_ovr = 0;
    end
    if (tclr) txq.delete();
    else if (drd && txq.size() != 0) begin void'(txq.pop_front()); popped = 1; end
    if (acc && wr) begin
      case (a)
        3'd0: begin if (txq.size() < DEPTH) txq.push_back(wd); m_thre = 0; end
        3'd1: begin if (wd[1] && !m_ier[1] && tx_pre == 0) m_thre = 1; m_ier = wd[1:0]; end
        3'd2: begin if (rclr) rxq.delete(); m_trig = wd[7:6]; end
        3'd7: m_scr = wd;
        default: ;
      endcase
    end
    if (dwr && !rclr) begin
      if (rxq.size() < DEPTH) rxq.push_back(dd);
      else m_ovr = 1;
    end
    if (tx_pre > 0 && txq.size() == 0 && (tclr || popped)) m_thre = 1;
    m_int = nxt_int;
    @(posedge clk_i); #1;
  endtask

  task automatic idle();                          step(0,0,0,0,0, 0,0, 0); endtask
  task automatic rd(input logic [2:0] a, input int c = -1); step(1,1,0,a,0, 0,0, 0, c); endtask
  task automatic wr(input logic [2:0] a, input logic [7:0] d); step(1,1,1,a,d, 0,0, 0); endtask
  task automatic dpush(input logic [7:0] d);      step(0,0,0,0,0, 1,d, 0); endtask
  task automatic dpop();                          step(0,0,0,0,0, 0,0, 1); endtask

  initial begin
    rst_i = 1'b1;
    PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
    dbg_data_i = 0; dbg_wr_strobe_i = 0; dbg_rd_strobe_i = 0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    rxq.delete(); txq.delete();
    m_ier = 0; m_trig = 0; m_scr = 0; m_ovr = 0; m_thre = 0; m_int = 0;

    // Reset state
    chk("rst_free", dbg_bytes_free_o, 16);
    chk("rst_avail", dbg_bytes_available_o, 0);
    chk("rst_int", int_o, 0);
    rd(5, 8'h60);
    rd(2, 8'hC1);

    // RX interrupt at trigger 1, in-order reads
    wr(1, 8'h01);
    dpush(8'hA5);
    dpush(8'h3C);
    rd(2, 8'hC4);
    chk("t2_int", int_o, 1);
    rd(0, 8'hA5);
    rd(0, 8'h3C);
    idle(); idle();
    chk("t2_int_low", int_o, 0);
    rd(0, 8'h00);                    // empty read: PSLVERR via model

    // Overrun
    wr(1, 8'h00);
    for (int i = 0; i < 17; i++) dpush(8'(i + 8'h10));
    chk("t3_free", dbg_bytes_free_o, 0);
    rd(5, 8'h63);
    rd(5, 8'h61);
    wr(2, 8'h02);

    // TX full, PSLVERR, push+pop when full
    for (int i = 0; i < 16; i++) wr(0, 8'(8'h40 + i));
    wr(0, 8'hEE);
    step(1,1,1,0,8'h77, 0,0, 1);
    chk("t4_avail", dbg_bytes_available_o, 16);
    for (int i = 0; i < 16; i++) dpop();
    dpop();                          // ignored on empty

    // THRE interrupt
    wr(1, 8'h00);
    wr(1, 8'h02);
    idle();
    rd(2, 8'hC2);
    rd(2, 8'hC1);
    wr(0, 8'h99);
    dpop();
    rd(2, 8'hC2);
    wr(1, 8'h00);

    // FCR clear racing a push, trigger 8
    wr(1, 8'h01);
    dpush(8'h01); dpush(8'h02);
    step(1,1,1,2,8'h82, 1,8'h55, 0);
    chk("t6_free", dbg_bytes_free_o, 16);
    for (int i = 0; i < 7; i++) dpush(8'(i));
    idle();
    chk("t6_int7", int_o, 0);
    dpush(8'h07);
    idle();
    chk("t6_int8", int_o, 1);
`ifdef ADBG_JSP_LEVEL_REGS_EN
    rd(3, 8);
`endif
    wr(2, 8'h06);
    wr(7, 8'h5A);
    rd(7, 8'h5A);

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      logic s, e, w, dw, dr;
      logic [2:0] a;
      logic [7:0] d;
      s  = ($urandom_range(0, 3) != 0);
      e  = s && ($urandom_range(0, 3) != 0);
      w  = $urandom_range(0, 1);
      a  = ($urandom_range(0, 9) < 4) ? 3'd0 : 3'($urandom_range(0, 7));
      d  = 8'($urandom);
      if (a == 3'd2 && w && $urandom_range(0, 3) != 0) d[2:1] = 2'b00;
      dw = ($urandom_range(0, 99) < ((n % 600) < 300 ? 70 : 25));
      dr = ($urandom_range(0, 99) < ((n % 600) < 300 ? 25 : 70));
      step(s, e, w, a, d, dw, 8'($urandom), dr);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
